// File: rtl/sw_pkg.sv
// Shared types and constants for the slide-switch debouncer.
package sw_pkg;

   localparam int unsigned WIDTH         = 3;
   localparam int unsigned SYNC_STAGES   = 2;
   localparam int unsigned STABLE_CYCLES = 4;

   // {enable, switch} carried as one vector through sync and filter
   typedef logic [2*WIDTH-1:0] sw_vec_t;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // Reset leaves downstream LEDs dark
   localparam logic [WIDTH-1:0] SW_RST = '0;
   localparam logic [WIDTH-1:0] EN_RST = '0;

endpackage

// File: rtl/switch_debouncer_sync_chain.sv
// N-bit multi-flop synchroniser; every stage clears on reset.
module sync_chain #(
   parameter int unsigned N      = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_stage [STAGES];

   // Shift the asynchronous input through STAGES flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces raw switch/enable codes into clk-domain registered buses with an update strobe.
module switch_debouncer
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH         = sw_pkg::WIDTH,
   parameter int unsigned SYNC_STAGES   = sw_pkg::SYNC_STAGES,
   parameter int unsigned STABLE_CYCLES = sw_pkg::STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   input  logic [WIDTH-1:0] en_in,
   output logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] enable,
   output logic             update
);

   localparam int unsigned VW = 2 * WIDTH;
   localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [VW-1:0] OUT_RST  = {WIDTH'(EN_RST), WIDTH'(SW_RST)};

   logic [VW-1:0] w_sync;
   logic [VW-1:0] r_cand,   w_cand_nxt;
   logic [CW-1:0] r_cnt,    w_cnt_nxt;
   state_t        r_state,  w_state_nxt;
   logic [VW-1:0] r_out,    w_out_nxt;
   logic          r_update, w_update_nxt;

   sync_chain #(
      .N      (VW),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d ({en_in, sw_in}),
      .o_q (w_sync)
   );

   // State, counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cand   <= '0;
         r_cnt    <= '0;
         r_state  <= ST_STABLE;
         r_out    <= OUT_RST;
         r_update <= 1'b0;
      end else begin
         r_cand   <= w_cand_nxt;
         r_cnt    <= w_cnt_nxt;
         r_state  <= w_state_nxt;
         r_out    <= w_out_nxt;
         r_update <= w_update_nxt;
      end
   end

   // Any change restarts the window; a full quiet window commits the candidate
   always_comb begin
      w_cand_nxt   = r_cand;
      w_cnt_nxt    = r_cnt;
      w_state_nxt  = r_state;
      w_out_nxt    = r_out;
      w_update_nxt = 1'b0;

      if (w_sync != r_cand) begin
         w_cand_nxt  = w_sync;
         w_cnt_nxt   = '0;
         w_state_nxt = (w_sync != r_out) ? ST_PENDING : ST_STABLE;
      end else if (r_state == ST_PENDING) begin
         if (r_cnt == CNT_LAST) begin
            w_out_nxt    = r_cand;
            w_update_nxt = 1'b1;
            w_state_nxt  = ST_STABLE;
            w_cnt_nxt    = '0;
         end else begin
            w_cnt_nxt = CW'(r_cnt + 1'b1);
         end
      end else begin
         w_cnt_nxt = '0;
      end
   end

   assign switch = r_out[WIDTH-1:0];
   assign enable = r_out[VW-1:WIDTH];
   assign update = r_update;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench: directed scenarios plus random bounce against a sample-history model.
module tb_switch_debouncer;

   localparam int unsigned W    = 3;
   localparam int unsigned SYNC = 2;
   localparam int unsigned STAB = 4;
   localparam int unsigned LAT  = SYNC + 1 + STAB;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] sw_in, en_in;
   logic [W-1:0] switch, enable;
   logic         update;

   int n_tests = 0;
   int n_fail  = 0;
   int n_upd   = 0;
   logic prev_upd = 1'b0;

   // Reference model: raw delay line and history of synced samples
   logic [2*W-1:0] m_rawq  [$];
   logic [2*W-1:0] m_xhist [$];
   logic [2*W-1:0] m_out;
   logic           m_upd;

   switch_debouncer #(
      .WIDTH         (W),
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STAB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sw_in  (sw_in),
      .en_in  (en_in),
      .switch (switch),
      .enable (enable),
      .update (update)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rawq  = {};
      m_xhist = {};
      for (int i = 0; i < int'(SYNC); i++) m_rawq.push_back('0);
      m_out = '0;
      m_upd = 1'b0;
   endtask

   // Output takes value v once STAB+1 consecutive synced samples all equal v and v differs
   task automatic model_edge(input logic [2*W-1:0] raw);
      logic [2*W-1:0] x;
      logic all_eq;
      m_rawq.push_back(raw);
      x = m_rawq.pop_front();
      m_xhist.push_back(x);
      if (m_xhist.size() > int'(STAB) + 1) void'(m_xhist.pop_front());
      all_eq = (m_xhist.size() == int'(STAB) + 1);
      foreach (m_xhist[i]) if (m_xhist[i] != x) all_eq = 1'b0;
      m_upd = all_eq && (x != m_out);
      if (m_upd) m_out = x;
   endtask

   // One clock with given raw inputs; compare DUT against model after the edge
   task automatic cycle(input logic [W-1:0] sw, input logic [W-1:0] en);
      sw_in = sw;
      en_in = en;
      @(posedge clk);
      model_edge({en, sw});
      #1;
      chk("switch", 8'(switch), 8'(m_out[W-1:0]));
      chk("enable", 8'(enable), 8'(m_out[2*W-1:W]));
      chk("update", 8'(update), 8'(m_upd));
      if (prev_upd) chk("update_b2b", 8'(update), 8'h00);
      prev_upd = update;
      if (update) n_upd++;
   endtask

   // Asynchronous reset pulse in the middle of a cycle; outputs must clear with no clock
   task automatic mid_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst_switch", 8'(switch), 8'h00);
      chk("rst_enable", 8'(enable), 8'h00);
      chk("rst_update", 8'(update), 8'h00);
      model_reset();
      prev_upd = 1'b0;
      #2 rst = 1'b0;
   endtask

   initial begin
      int base;
      logic [2*W-1:0] v;
      int hold;

      rst   = 1'b1;
      sw_in = '0;
      en_in = '0;
      model_reset();
      #1;
      chk("por_switch", 8'(switch), 8'h00);
      chk("por_enable", 8'(enable), 8'h00);
      chk("por_update", 8'(update), 8'h00);
      #12 rst = 1'b0;

      // Basic commit latency: sw=5, en=4
      base = n_upd;
      for (int i = 1; i <= int'(LAT) + 2; i++) begin
         cycle(3'b101, 3'b100);
         if (i == int'(LAT) - 1) chk("lat_pre_switch", 8'(switch), 8'h00);
         if (i == int'(LAT)) begin
            chk("lat_switch", 8'(switch), 8'h05);
            chk("lat_enable", 8'(enable), 8'h04);
            chk("lat_update", 8'(update), 8'h01);
         end
         if (i == int'(LAT) + 1) chk("lat_update_drop", 8'(update), 8'h00);
      end
      chk("lat_upd_count", 8'(n_upd - base), 8'h01);

      // Reset asserted mid-cycle with committed outputs
      mid_reset();

      // Short pulse must not commit
      base = n_upd;
      for (int i = 0; i < 3; i++) cycle(3'b011, 3'b000);
      for (int i = 0; i < 10; i++) cycle(3'b000, 3'b000);
      chk("pulse_upd_count", 8'(n_upd - base), 8'h00);
      chk("pulse_switch", 8'(switch), 8'h00);

      // Toggle 7/0 every two cycles, then hold 7
      base = n_upd;
      for (int i = 0; i < 20; i++) cycle(((i / 2) % 2 == 0) ? 3'b111 : 3'b000, 3'b000);
      for (int i = 1; i <= 10; i++) begin
         cycle(3'b111, 3'b000);
         if (i == int'(LAT) - 1) chk("tog_pre_switch", 8'(switch), 8'h00);
         if (i == int'(LAT)) chk("tog_switch", 8'(switch), 8'h07);
      end
      chk("tog_upd_count", 8'(n_upd - base), 8'h01);

      // Reset while pending toward 6, then hold 6
      mid_reset();
      for (int i = 0; i < 4; i++) cycle(3'b110, 3'b000);
      mid_reset();
      for (int i = 1; i <= 9; i++) begin
         cycle(3'b110, 3'b000);
         if (i == int'(LAT) - 1) chk("rp_pre_switch", 8'(switch), 8'h00);
         if (i == int'(LAT)) chk("rp_switch", 8'(switch), 8'h06);
      end

      // Single enable bit change
      for (int i = 0; i < 10; i++) cycle(3'b110, 3'b100);
      base = n_upd;
      for (int i = 0; i < 10; i++) cycle(3'b110, 3'b101);
      chk("en_upd_count", 8'(n_upd - base), 8'h01);
      chk("en_enable", 8'(enable), 8'h05);
      chk("en_switch", 8'(switch), 8'h06);

      // Random bounce: held values, single-bit flips, occasional reset
      v = '0;
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 39) == 0) mid_reset();
         if ($urandom_range(0, 1) == 0) v = 6'($urandom);
         else v = v ^ 6'(1 << $urandom_range(0, 2*W-1));
         hold = $urandom_range(1, 9);
         for (int i = 0; i < hold; i++) cycle(v[W-1:0], v[2*W-1:W]);
      end
      for (int i = 0; i < 10; i++) cycle(v[W-1:0], v[2*W-1:W]);
      chk("rand_final", 8'({enable, switch}), 8'(v));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
